qam_modulator_param: RTL and testbench

Parametrised, single-clock successor to the fixed 16-QAM chain. It runs these stages with clock enables instead of derived clocks:
- internal PRBS-7 bit source or external serial bit source
- runtime-selectable QPSK/16-QAM/64-QAM symbol mapper
- DDS quadrature carrier
- I/Q multipliers and a combined passband output

It sits at the top of the modulator path and feeds the DAC/capture logic.

---
 rtl/qam_modulator_param.sv | 187 ++++++++++++++++++
 tb/tb_qam_modulator_param.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/qam_modulator_param.sv
// rtl/qam_modulator_param.sv - clock-enabled PRBS/serial source, QPSK/16/64-QAM mapper, DDS carrier and I/Q upconverter
module qam_modulator_param #(
    parameter int BIT_DIV = 8,
    parameter int PHASE_W = 16,
    parameter int CAR_W   = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              mode,
    input  logic                    src_sel,
    input  logic                    din,
    input  logic [PHASE_W-1:0]      fcw,
    output logic                    bit_tick,
    output logic                    prbs_bit,
    output logic                    sym_strobe,
    output logic signed [3:0]       i_level,
    output logic signed [3:0]       q_level,
    output logic signed [CAR_W-1:0] sin_out,
    output logic signed [CAR_W-1:0] cos_out,
    output logic signed [CAR_W+3:0] i_mod,
    output logic signed [CAR_W+3:0] q_mod,
    output logic signed [CAR_W+4:0] qam_out
);
    localparam int CNT_W = $clog2(BIT_DIV);

    // Quarter-wave magnitudes are sin(2*pi*m/64) scaled by 1e9, then rounded to the carrier amplitude.
    function automatic logic signed [CAR_W-1:0] sin_entry(input int n);
        longint q;
        longint a;
        int     m;
        m = n % 32;
        if (m > 16) m = 32 - m;
        case (m)
            0:       q = 0;
            1:       q = 98017140;
            2:       q = 195090322;
            3:       q = 290284677;
            4:       q = 382683432;
            5:       q = 471396737;
            6:       q = 555570233;
            7:       q = 634393284;
            8:       q = 707106781;
            9:       q = 773010453;
            10:      q = 831469612;
            11:      q = 881921264;
            12:      q = 923879533;
            13:      q = 956940336;
            14:      q = 980785280;
            15:      q = 995184727;
            default: q = 1000000000;
        endcase
        a = (q * ((longint'(1) << (CAR_W - 1)) - 1) + 500000000) / 1000000000;
        if (n >= 32) a = -a;
        return CAR_W'(a);
    endfunction

    logic signed [CAR_W-1:0] w_tab [64];
    for (genvar g = 0; g < 64; g++) begin : g_tab
        assign w_tab[g] = sin_entry(g);
    end

    logic [CNT_W-1:0]        r_cnt;
    logic [6:0]              r_prbs;
    logic                    r_prbs_bit;
    logic [5:0]              r_col;
    logic [2:0]              r_nbits;
    logic [1:0]              r_k;
    logic signed [3:0]       r_i;
    logic signed [3:0]       r_q;
    logic                    r_strobe;
    logic [PHASE_W-1:0]      r_phase;
    logic signed [CAR_W-1:0] r_sin;
    logic signed [CAR_W-1:0] r_cos;
    logic signed [CAR_W+3:0] r_imod;
    logic signed [CAR_W+3:0] r_qmod;
    logic signed [CAR_W+4:0] r_qam;

    logic       w_tick;
    logic       w_fb;
    logic       w_bit;
    logic [5:0] w_col;
    logic [1:0] w_k_mode;
    logic [1:0] w_k;
    logic       w_done;
    logic [2:0] w_vi;
    logic [2:0] w_vq;
    logic [3:0] w_span;
    logic [5:0] w_idx;

    assign w_tick = (r_cnt == CNT_W'(BIT_DIV - 1));
    assign w_fb   = r_prbs[6] ^ r_prbs[5];
    assign w_bit  = src_sel ? din : w_fb;
    assign w_col  = {r_col[4:0], w_bit};
    assign w_idx  = r_phase[PHASE_W-1 -: 6];

    // The rail width is taken from mode only on a symbol's first bit, then held in r_k.
    assign w_k    = (r_nbits == 3'd0) ? w_k_mode : r_k;
    assign w_done = ((r_nbits + 3'd1) == {w_k, 1'b0});

    always_comb begin
        w_k_mode = 2'd2;
        case (mode)
            2'd0:    w_k_mode = 2'd1;
            2'd2:    w_k_mode = 2'd3;
            default: w_k_mode = 2'd2;
        endcase
    end

    always_comb begin
        w_vi   = {1'b0, w_col[3:2]};
        w_vq   = {1'b0, w_col[1:0]};
        w_span = 4'd3;
        case (w_k)
            2'd1: begin
                w_vi   = {2'b00, w_col[1]};
                w_vq   = {2'b00, w_col[0]};
                w_span = 4'd1;
            end
            2'd3: begin
                w_vi   = w_col[5:3];
                w_vq   = w_col[2:0];
                w_span = 4'd7;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_prbs     <= 7'h7F;
            r_prbs_bit <= 1'b0;
            r_col      <= '0;
            r_nbits    <= '0;
            r_k        <= 2'd1;
            r_i        <= '0;
            r_q        <= '0;
            r_strobe   <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            r_cnt    <= w_tick ? '0 : r_cnt + 1'b1;
            if (w_tick) begin
                r_prbs     <= {r_prbs[5:0], w_fb};
                r_prbs_bit <= w_fb;
                r_col      <= w_col;
                if (r_nbits == 3'd0) r_k <= w_k_mode;
                if (w_done) begin
                    r_nbits  <= '0;
                    r_i      <= {w_vi, 1'b0} - w_span;
                    r_q      <= {w_vq, 1'b0} - w_span;
                    r_strobe <= 1'b1;
                end else begin
                    r_nbits <= r_nbits + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase <= '0;
            r_sin   <= '0;
            r_cos   <= '0;
            r_imod  <= '0;
            r_qmod  <= '0;
            r_qam   <= '0;
        end else begin
            r_phase <= r_phase + fcw;
            r_sin   <= w_tab[w_idx];
            r_cos   <= w_tab[w_idx + 6'd16];
            r_imod  <= (CAR_W+4)'(r_i) * (CAR_W+4)'(r_cos);
            r_qmod  <= (CAR_W+4)'(r_q) * (CAR_W+4)'(r_sin);
            r_qam   <= (CAR_W+5)'(r_imod) - (CAR_W+5)'(r_qmod);
        end
    end

    assign bit_tick   = w_tick;
    assign prbs_bit   = r_prbs_bit;
    assign sym_strobe = r_strobe;
    assign i_level    = r_i;
    assign q_level    = r_q;
    assign sin_out    = r_sin;
    assign cos_out    = r_cos;
    assign i_mod      = r_imod;
    assign q_mod      = r_qmod;
    assign qam_out    = r_qam;
endmodule

// File: tb/tb_qam_modulator_param.sv
// tb/tb_qam_modulator_param.sv - randomized scoreboard bench for qam_modulator_param
module tb_qam_modulator_param;
    localparam int BIT_DIV = 8;
    localparam int PHASE_W = 16;
    localparam int CAR_W   = 10;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [1:0]              mode = 2'd0;
    logic                    src_sel = 1'b0;
    logic                    din = 1'b0;
    logic [PHASE_W-1:0]      fcw = '0;
    logic                    bit_tick;
    logic                    prbs_bit;
    logic                    sym_strobe;
    logic signed [3:0]       i_level;
    logic signed [3:0]       q_level;
    logic signed [CAR_W-1:0] sin_out;
    logic signed [CAR_W-1:0] cos_out;
    logic signed [CAR_W+3:0] i_mod;
    logic signed [CAR_W+3:0] q_mod;
    logic signed [CAR_W+4:0] qam_out;

    qam_modulator_param #(.BIT_DIV(BIT_DIV), .PHASE_W(PHASE_W), .CAR_W(CAR_W)) dut (
        .clk(clk), .rst(rst), .mode(mode), .src_sel(src_sel), .din(din), .fcw(fcw),
        .bit_tick(bit_tick), .prbs_bit(prbs_bit), .sym_strobe(sym_strobe),
        .i_level(i_level), .q_level(q_level), .sin_out(sin_out), .cos_out(cos_out),
        .i_mod(i_mod), .q_mod(q_mod), .qam_out(qam_out)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int n_sym = 0;

    int m_edges, m_phase, m_k, m_i, m_q, m_sin, m_cos, m_imod, m_qmod, m_qam;
    bit m_prbs, m_strobe, m_ticked;
    bit hist[$];
    bit sbits[$];
    bit din_q[$];
    int exp_i[$];
    int exp_q[$];
    bit rnd_mode = 0, rnd_fcw = 0, rnd_src = 0;

    function automatic int tab(input int n);
        real r;
        r = $sin(2.0 * 3.141592653589793 * n / 64.0) * ((2.0 ** (CAR_W - 1)) - 1.0);
        return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_edges = 0; m_phase = 0; m_k = 1; m_i = 0; m_q = 0;
        m_sin = 0; m_cos = 0; m_imod = 0; m_qmod = 0; m_qam = 0;
        m_prbs = 0; m_strobe = 0; m_ticked = 0;
        hist.delete();
        repeat (7) hist.push_back(1'b1);
        sbits.delete();
        exp_i.delete();
        exp_q.delete();
    endtask

    // Output bit n of x^7+x^6+1 from an all-ones seed is y[n-7]^y[n-6]; carrier from the ideal sine.
    task automatic model_step();
        int n_imod, n_qmod, n_qam, n_sin, n_cos, idx, vi, vq;
        bit y, b;
        n_imod = m_i * m_cos;
        n_qmod = m_q * m_sin;
        n_qam  = m_imod - m_qmod;
        idx    = m_phase / (2 ** (PHASE_W - 6));
        n_sin  = tab(idx);
        n_cos  = tab((idx + 16) % 64);
        m_phase = (m_phase + int'(fcw)) % (2 ** PHASE_W);
        m_strobe = 0;
        m_ticked = (m_edges % BIT_DIV == BIT_DIV - 1);
        if (m_ticked) begin
            y = hist[0] ^ hist[1];
            hist.push_back(y);
            void'(hist.pop_front());
            m_prbs = y;
            b = src_sel ? din : y;
            sbits.push_back(b);
            if (sbits.size() == 1) m_k = (mode == 2'd0) ? 1 : (mode == 2'd2) ? 3 : 2;
            if (sbits.size() == 2 * m_k) begin
                vi = 0;
                vq = 0;
                for (int j = 0; j < m_k; j++) vi = vi * 2 + int'(sbits[j]);
                for (int j = m_k; j < 2 * m_k; j++) vq = vq * 2 + int'(sbits[j]);
                m_i = 2 * vi - (2 ** m_k - 1);
                m_q = 2 * vq - (2 ** m_k - 1);
                exp_i.push_back(m_i);
                exp_q.push_back(m_q);
                m_strobe = 1;
                sbits.delete();
            end
        end
        m_edges++;
        m_sin = n_sin; m_cos = n_cos;
        m_imod = n_imod; m_qmod = n_qmod; m_qam = n_qam;
    endtask

    task automatic drive_din();
        din = (din_q.size() > 0) ? din_q.pop_front() : 1'($urandom_range(0, 1));
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            if (!rst) model_step();
            #2;
            if (m_ticked) drive_din();
            if (rnd_mode && $urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
            if (rnd_fcw && $urandom_range(0, 63) == 0)
                fcw = ($urandom_range(0, 7) == 0) ? '0 : PHASE_W'($urandom);
            if (rnd_src && $urandom_range(0, 31) == 0) src_sel = ~src_sel;
        end
    endtask

    task automatic apply_reset(input int n);
        rst = 1'b1;
        model_reset();
        repeat (n) @(posedge clk);
        #2;
        rst = 1'b0;
        drive_din();
    endtask

    initial begin
        int ei, eq;
        forever begin
            @(negedge clk);
            chk("bit_tick", int'(bit_tick), int'(m_edges % BIT_DIV == BIT_DIV - 1));
            chk("prbs_bit", int'(prbs_bit), int'(m_prbs));
            chk("sym_strobe", int'(sym_strobe), int'(m_strobe));
            chk("i_level", int'(i_level), m_i);
            chk("q_level", int'(q_level), m_q);
            chk("sin_out", int'(sin_out), m_sin);
            chk("cos_out", int'(cos_out), m_cos);
            chk("i_mod", int'(i_mod), m_imod);
            chk("q_mod", int'(q_mod), m_qmod);
            chk("qam_out", int'(qam_out), m_qam);
            if (sym_strobe) begin
                chk("sym_pending", int'(exp_i.size() > 0), 1);
                if (exp_i.size() > 0) begin
                    ei = exp_i.pop_front();
                    eq = exp_q.pop_front();
                    chk("sb_i_level", int'(i_level), ei);
                    chk("sb_q_level", int'(q_level), eq);
                    n_sym++;
                end
            end
        end
    end

    initial begin
        model_reset();
        mode = 2'd0; src_sel = 1'b0; fcw = PHASE_W'(1 << (PHASE_W - 6));
        apply_reset(3);
        run(BIT_DIV * 10);

        mode = 2'd1;
        apply_reset(2);
        run(BIT_DIV * 260);

        src_sel = 1'b1; mode = 2'd2;
        din_q = '{1, 1, 1, 0, 0, 0, 1, 0, 1, 0, 1, 0};
        apply_reset(2);
        run(BIT_DIV * 20);

        rnd_mode = 1; rnd_fcw = 1; rnd_src = 1;
        run(3000);

        rnd_mode = 0; rnd_fcw = 0; rnd_src = 0;
        mode = 2'd2; fcw = PHASE_W'(777);
        run(BIT_DIV * 7);
        for (int t = 0; t < 200; t++) begin
            if (sbits.size() > 0) break;
            run(1);
        end
        chk("partial_symbol_reached", int'(sbits.size() > 0), 1);
        rst = 1'b1;
        #1;
        chk("async_rst_i_level", int'(i_level), 0);
        chk("async_rst_sin_out", int'(sin_out), 0);
        chk("async_rst_cos_out", int'(cos_out), 0);
        chk("async_rst_qam_out", int'(qam_out), 0);
        chk("async_rst_prbs_bit", int'(prbs_bit), 0);
        #1;
        src_sel = 1'b0; mode = 2'd1;
        apply_reset(2);
        run(BIT_DIV * 20);

        @(negedge clk);
        #1;
        chk("sym_queue_drained", exp_i.size(), 0);
        chk("symbols_seen", int'(n_sym > 100), 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
